// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB slave model with per-slave word memory, a programmable wait-state
// generator, optional error signalling and a sticky protocol-violation flag.
//
// Build option: define APB_SLVERR_EN to report address/select errors on pslverr and to
// suppress errored accesses. Without it pslverr is tied low, addresses wrap on
// paddr[IW+1:2] and a multi-hot psel accesses the lowest-numbered selected slave.
//
// Ports:
//   Hclk, Hreset         clock (rising edge), asynchronous active-high reset
//   pwrite, penable      APB direction / enable from the bridge
//   psel[NUM_SLV]        one-hot slave select
//   paddr, pwdata        byte address, write data
//   *_out                combinational pass-through of the matching inputs
//   pr_data              read data, zero outside a completing, error-free read
//   pready               transfer complete (last access cycle)
//   pslverr              transfer error, qualified by pready
//   prot_err             sticky protocol-violation flag, cleared only by Hreset
//
// Phase tracking: the APB setup cycle is the cycle where the registered state is idle and
// psel is non-zero with penable low. The edge ending it enters the access state, loads the
// wait counter and captures psel/paddr; the setup-to-access rules (penable high, psel and
// paddr stable) are then checked in the first access cycle. This keeps a transfer at
// 2 + WAIT_CYCLES cycles with pready high only in the last one.
module apb_slave_mem #(
  parameter int unsigned NUM_SLV     = 3,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic               Hclk,
  input  logic               Hreset,
  input  logic               pwrite,
  input  logic               penable,
  input  logic [NUM_SLV-1:0] psel,
  input  logic [ADDR_W-1:0]  paddr,
  input  logic [DATA_W-1:0]  pwdata,
  output logic               pwrite_out,
  output logic               penable_out,
  output logic [NUM_SLV-1:0] psel_out,
  output logic [ADDR_W-1:0]  paddr_out,
  output logic [DATA_W-1:0]  pwdata_out,
  output logic [DATA_W-1:0]  pr_data,
  output logic               pready,
  output logic               pslverr,
  output logic               prot_err
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned SW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic                first_q;
  logic [NUM_SLV-1:0]  psel_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic                prot_err_q;
  logic [DATA_W-1:0]   mem_q [NUM_SLV][DEPTH];

  logic [IW-1:0]       idx;
  logic [SW-1:0]       slv;
  logic                sel_any;
  logic                acc_err;
  logic                setup_bad;
  logic                wr_en;

  // Pass-through of the bridge outputs
  assign pwrite_out  = pwrite;
  assign penable_out = penable;
  assign psel_out    = psel;
  assign paddr_out   = paddr;
  assign pwdata_out  = pwdata;

  assign idx     = paddr[IW+1:2];
  assign sel_any = |psel;

  // Lowest-numbered selected slave
  always_comb begin
    slv = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if (psel[i]) slv = SW'(i);
    end
  end

`ifdef APB_SLVERR_EN
  logic addr_err;
  logic sel_err;
  assign addr_err = (paddr[1:0] != 2'b00) || (|(paddr >> (IW + 2)));
  assign sel_err  = sel_any && ((psel & (psel - NUM_SLV'(1))) != '0);
  assign acc_err  = addr_err || sel_err;
  assign pslverr  = pready && acc_err;
`else
  assign acc_err  = 1'b0;
  assign pslverr  = 1'b0;
`endif

  // First access cycle must carry penable with the captured select and address
  assign setup_bad = first_q && (!penable || (psel != psel_q) || (paddr != paddr_q));

  assign pready  = (state_q == StAccess) && (cnt_q == 4'd0) && !setup_bad;
  assign wr_en   = pready && pwrite && sel_any && !acc_err;
  assign pr_data = (pready && !pwrite && sel_any && !acc_err) ? mem_q[slv][idx] : '0;
  assign prot_err = prot_err_q;

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      first_q    <= 1'b0;
      psel_q     <= '0;
      paddr_q    <= '0;
      prot_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (penable) begin
            // Enable without a setup cycle: flag it and ignore the cycle
            prot_err_q <= 1'b1;
          end else if (sel_any) begin
            state_q <= StAccess;
            cnt_q   <= 4'(WAIT_CYCLES);
            first_q <= 1'b1;
            psel_q  <= psel;
            paddr_q <= paddr;
          end
        end
        StAccess: begin
          first_q <= 1'b0;
          if (pready) begin
            state_q <= StIdle;
          end else if (setup_bad || !sel_any) begin
            // Broken setup handshake or select dropped before pready: abort
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            prot_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      for (int s = 0; s < NUM_SLV; s++) begin
        for (int w = 0; w < DEPTH; w++) begin
          mem_q[s][w] <= '0;
        end
      end
    end else if (wr_en) begin
      mem_q[slv][idx] <= pwdata;
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
module tb_apb_slave_mem;

  logic        Hclk = 1'b0;
  logic        Hreset = 1'b1;
  logic        pwrite = 1'b0;
  logic        penable = 1'b0;
  logic [2:0]  psel = '0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic        pwrite_out;
  logic        penable_out;
  logic [2:0]  psel_out;
  logic [31:0] paddr_out;
  logic [31:0] pwdata_out;
  logic [31:0] pr_data;
  logic        pready;
  logic        pslverr;
  logic        prot_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd;
  logic        se;
  int          cyc;
  int          low;

  apb_slave_mem #(
    .NUM_SLV    (3),
    .DATA_W     (32),
    .ADDR_W     (32),
    .DEPTH      (16),
    .WAIT_CYCLES(3)
  ) dut (
    .Hclk       (Hclk),
    .Hreset     (Hreset),
    .pwrite     (pwrite),
    .penable    (penable),
    .psel       (psel),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .pwrite_out (pwrite_out),
    .penable_out(penable_out),
    .psel_out   (psel_out),
    .paddr_out  (paddr_out),
    .pwdata_out (pwdata_out),
    .pr_data    (pr_data),
    .pready     (pready),
    .pslverr    (pslverr),
    .prot_err   (prot_err)
  );

  always #5 Hclk = ~Hclk;

  // One APB transfer followed by an idle cycle; the pready wait is bounded
  task automatic apb_xfer(input logic [2:0] sel, input logic [31:0] addr, input logic write,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic slverr, output int cycles, output int lowc);
    bit done = 0;
    int k = 0;
    rdata = '0; slverr = 1'b0; lowc = 0;
    @(posedge Hclk); #1;
    psel = sel; paddr = addr; pwrite = write; pwdata = wdata; penable = 1'b0;
    cycles = 1;
    @(posedge Hclk); #1;
    penable = 1'b1;
    while (!done && k < 20) begin
      @(negedge Hclk);
      cycles++;
      if (pready === 1'b1) begin
        rdata = pr_data; slverr = pslverr; done = 1;
      end else begin
        lowc++;
        @(posedge Hclk); #1;
      end
      k++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL xfer_timeout: pready never rose (got %b, required 1)", pready);
    end
    @(posedge Hclk); #1;
    psel = '0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge Hclk); #1;
    Hreset = 1'b1;
    @(posedge Hclk); #1;
    Hreset = 1'b0;
  endtask

  task automatic test_reset();
    psel = 3'b101; paddr = 32'h1234_5678; pwdata = 32'h9ABC_DEF0; pwrite = 1'b1;
    penable = 1'b1;
    @(negedge Hclk);
    checks++; if (pready !== 1'b0) begin errors++; $display("FAIL rst_pready: got %b required 0", pready); end
    checks++; if (pslverr !== 1'b0) begin errors++; $display("FAIL rst_pslverr: got %b required 0", pslverr); end
    checks++; if (pr_data !== 32'h0) begin errors++; $display("FAIL rst_prdata: got %h required 0", pr_data); end
    checks++; if (prot_err !== 1'b0) begin errors++; $display("FAIL rst_proterr: got %b required 0", prot_err); end
    checks++; if (paddr_out !== 32'h1234_5678) begin errors++; $display("FAIL pass_paddr: got %h required 12345678", paddr_out); end
    checks++; if (pwdata_out !== 32'h9ABC_DEF0) begin errors++; $display("FAIL pass_pwdata: got %h required 9abcdef0", pwdata_out); end
    checks++; if ({psel_out, pwrite_out, penable_out} !== 5'b10111) begin errors++; $display("FAIL pass_ctrl: got %b required 10111", {psel_out, pwrite_out, penable_out}); end
    psel = '0; paddr = '0; pwdata = '0; pwrite = 1'b0; penable = 1'b0;
    @(posedge Hclk); #1;
    Hreset = 1'b0;
    @(negedge Hclk);
    checks++; if (prot_err !== 1'b0) begin errors++; $display("FAIL rst_release_proterr: got %b required 0", prot_err); end
  endtask

  task automatic test_write_read();
    apb_xfer(3'b010, 32'h08, 1'b1, 32'hDEAD_BEEF, rd, se, cyc, low);
    checks++; if (se !== 1'b0) begin errors++; $display("FAIL wr_slverr: got %b required 0", se); end
    apb_xfer(3'b010, 32'h08, 1'b0, 32'h0, rd, se, cyc, low);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_s1_08: got %h required deadbeef", rd); end
    apb_xfer(3'b001, 32'h08, 1'b0, 32'h0, rd, se, cyc, low);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rd_s0_08: got %h required 0", rd); end
    apb_xfer(3'b100, 32'h3C, 1'b1, 32'h1234_5678, rd, se, cyc, low);
    apb_xfer(3'b100, 32'h3C, 1'b0, 32'h0, rd, se, cyc, low);
    checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL rd_s2_3c: got %h required 12345678", rd); end
    apb_xfer(3'b010, 32'h3C, 1'b0, 32'h0, rd, se, cyc, low);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rd_s1_3c: got %h required 0", rd); end
  endtask

  task automatic test_wait_states();
    apb_xfer(3'b001, 32'h00, 1'b0, 32'h0, rd, se, cyc, low);
    checks++; if (low !== 3) begin errors++; $display("FAIL wait_low_cycles: got %0d required 3", low); end
    checks++; if (cyc !== 5) begin errors++; $display("FAIL wait_total_cycles: got %0d required 5", cyc); end
  endtask

  task automatic test_addr_err();
    apb_xfer(3'b001, 32'h40, 1'b1, 32'hA5A5_1234, rd, se, cyc, low);
`ifdef APB_SLVERR_EN
    checks++; if (se !== 1'b1) begin errors++; $display("FAIL addr_err_slverr: got %b required 1", se); end
    apb_xfer(3'b001, 32'h00, 1'b0, 32'h0, rd, se, cyc, low);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL addr_err_rd00: got %h required 0", rd); end
`else
    checks++; if (se !== 1'b0) begin errors++; $display("FAIL addr_wrap_slverr: got %b required 0", se); end
    apb_xfer(3'b001, 32'h00, 1'b0, 32'h0, rd, se, cyc, low);
    checks++; if (rd !== 32'hA5A5_1234) begin errors++; $display("FAIL addr_wrap_rd00: got %h required a5a51234", rd); end
`endif
    checks++; if (se !== 1'b0) begin errors++; $display("FAIL rd00_slverr: got %b required 0", se); end
  endtask

  task automatic test_sel_err();
    apb_xfer(3'b011, 32'h10, 1'b1, 32'h0000_0077, rd, se, cyc, low);
`ifdef APB_SLVERR_EN
    checks++; if (se !== 1'b1) begin errors++; $display("FAIL sel_err_slverr: got %b required 1", se); end
    apb_xfer(3'b001, 32'h10, 1'b0, 32'h0, rd, se, cyc, low);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sel_err_rd_s0: got %h required 0", rd); end
`else
    checks++; if (se !== 1'b0) begin errors++; $display("FAIL multihot_slverr: got %b required 0", se); end
    apb_xfer(3'b001, 32'h10, 1'b0, 32'h0, rd, se, cyc, low);
    checks++; if (rd !== 32'h0000_0077) begin errors++; $display("FAIL multihot_rd_s0: got %h required 77", rd); end
`endif
    apb_xfer(3'b010, 32'h10, 1'b0, 32'h0, rd, se, cyc, low);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL multihot_rd_s1: got %h required 0", rd); end
  endtask

  task automatic test_prot_err();
    @(posedge Hclk); #1;
    psel = '0; penable = 1'b1;
    @(negedge Hclk);
    checks++; if (prot_err !== 1'b0) begin errors++; $display("FAIL prot_before_edge: got %b required 0", prot_err); end
    checks++; if (pready !== 1'b0) begin errors++; $display("FAIL prot_idle_pready: got %b required 0", pready); end
    @(posedge Hclk); #1;
    penable = 1'b0;
    @(negedge Hclk);
    checks++; if (prot_err !== 1'b1) begin errors++; $display("FAIL prot_set: got %b required 1", prot_err); end
    apb_xfer(3'b010, 32'h08, 1'b0, 32'h0, rd, se, cyc, low);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL prot_rd_after: got %h required deadbeef", rd); end
    checks++; if (prot_err !== 1'b1) begin errors++; $display("FAIL prot_sticky: got %b required 1", prot_err); end
    pulse_reset();
    @(negedge Hclk);
    checks++; if (prot_err !== 1'b0) begin errors++; $display("FAIL prot_cleared: got %b required 0", prot_err); end
    // Select dropped during the wait states of a write
    @(posedge Hclk); #1;
    psel = 3'b001; paddr = 32'h14; pwrite = 1'b1; pwdata = 32'h0000_0055; penable = 1'b0;
    @(posedge Hclk); #1;
    penable = 1'b1;
    @(posedge Hclk); #1;
    psel = '0; penable = 1'b0; pwrite = 1'b0;
    @(negedge Hclk);
    checks++; if (pready !== 1'b0) begin errors++; $display("FAIL drop_pready: got %b required 0", pready); end
    @(negedge Hclk);
    checks++; if (prot_err !== 1'b1) begin errors++; $display("FAIL drop_proterr: got %b required 1", prot_err); end
    apb_xfer(3'b001, 32'h14, 1'b0, 32'h0, rd, se, cyc, low);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL drop_no_write: got %h required 0", rd); end
    checks++; if (cyc !== 5) begin errors++; $display("FAIL drop_next_xfer_len: got %0d required 5", cyc); end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    int k = 0;
    @(posedge Hclk); #1;
    psel = 3'b100; paddr = 32'h04; pwrite = 1'b1; pwdata = 32'hCAFE_F00D; penable = 1'b0;
    @(posedge Hclk); #1;
    penable = 1'b1;
    while (!seen && k < 20) begin
      @(negedge Hclk);
      if (pready === 1'b1) seen = 1;
      else begin @(posedge Hclk); #1; end
      k++;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL mid_pready_seen: got %b required 1", seen); end
    Hreset = 1'b1;
    #1;
    checks++; if (pready !== 1'b0) begin errors++; $display("FAIL mid_rst_pready: got %b required 0", pready); end
    checks++; if (prot_err !== 1'b0) begin errors++; $display("FAIL mid_rst_proterr: got %b required 0", prot_err); end
    checks++; if ({pslverr, pr_data} !== 33'h0) begin errors++; $display("FAIL mid_rst_outs: got %h required 0", {pslverr, pr_data}); end
    checks++; if (psel_out !== 3'b100) begin errors++; $display("FAIL mid_rst_pass: got %b required 100", psel_out); end
    @(posedge Hclk); #1;
    Hreset = 1'b0; psel = '0; penable = 1'b0; pwrite = 1'b0;
    apb_xfer(3'b100, 32'h04, 1'b0, 32'h0, rd, se, cyc, low);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mid_rst_rd: got %h required 0", rd); end
    apb_xfer(3'b010, 32'h08, 1'b0, 32'h0, rd, se, cyc, low);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mid_rst_cleared: got %h required 0", rd); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wait_states();
    test_addr_err();
    test_sel_err();
    test_prot_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
